// File: rtl/noc_pkg.sv
// Shared NoC types: flit width, flit-type encoding, VC id width and per-VC framing state.
package noc_pkg;

    localparam int unsigned FLIT_W   = 34;
    localparam int unsigned TYPE_MSB = FLIT_W - 1;
    localparam int unsigned TYPE_LSB = FLIT_W - 2;
    localparam int unsigned VC_ID_W  = 2;

    typedef enum logic [1:0] {
        FT_HEAD   = 2'b00,
        FT_BODY   = 2'b01,
        FT_SINGLE = 2'b10,
        FT_TAIL   = 2'b11
    } flit_type_t;

    typedef enum logic {
        FS_IDLE = 1'b0,
        FS_PKT  = 1'b1
    } frame_state_t;

    // A flit type that cannot legally follow the current framing state.
    function automatic logic frame_violation(input frame_state_t s, input flit_type_t t);
        if (s == FS_IDLE) begin
            return (t == FT_BODY) || (t == FT_TAIL);
        end
        return (t == FT_HEAD) || (t == FT_SINGLE);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping modulo N.
module rr_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]       req,
    input  logic [VC_ID_W-1:0] ptr,
    output logic [N-1:0]       grant,
    output logic [VC_ID_W-1:0] idx
);

    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            for (int j = 0; j < int'(N); j++) begin
                if (!found && req[j] && (j == (int'(ptr) + i) % int'(N))) begin
                    grant[j] = 1'b1;
                    idx      = VC_ID_W'(j);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vc_link_tx.sv
// Router output-link transmitter: per-flit round-robin over eligible VCs into one registered slot.
// Optional per-VC head/tail framing check enabled by VC_LINK_TX_FRAME_CHECK_EN.
module vc_link_tx #(
    parameter int unsigned NUM_VC = 3,
    parameter int unsigned FLIT_W = noc_pkg::FLIT_W
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic [NUM_VC*FLIT_W-1:0]    fdata_i,
    input  logic [NUM_VC-1:0]           valid_i,
    output logic [NUM_VC-1:0]           ready_o,
    output logic [FLIT_W-1:0]           fdata_o,
    output logic [noc_pkg::VC_ID_W-1:0] vc_id_o,
    output logic                        valid_o,
    input  logic [NUM_VC-1:0]           ready_i,
    output logic                        err_o
);
    import noc_pkg::*;

    localparam int unsigned IW = VC_ID_W;

    logic [NUM_VC-1:0] eligible;
    logic [NUM_VC-1:0] arb_grant;
    logic [NUM_VC-1:0] grant;
    logic [IW-1:0]     arb_idx;
    logic [IW-1:0]     rr_ptr;
    logic [3:0]        ready_pad;
    logic              slot_free;
    logic              any_grant;
    logic [FLIT_W-1:0] sel_flit;

    // Padded so vc_id_o can index it for any NUM_VC up to 4.
    assign ready_pad = 4'(ready_i);
    assign slot_free = !valid_o || ready_pad[vc_id_o];
    assign eligible  = valid_i & ready_i;

    rr_arbiter #(.N(NUM_VC)) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign grant     = (arst && slot_free) ? arb_grant : '0;
    assign any_grant = |grant;
    assign ready_o   = grant;

    always_comb begin
        sel_flit = '0;
        for (int v = 0; v < int'(NUM_VC); v++) begin
            if (grant[v]) begin
                sel_flit = fdata_i[v*FLIT_W +: FLIT_W];
            end
        end
    end

    // Output slot and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!arst) begin
            valid_o <= 1'b0;
            fdata_o <= '0;
            vc_id_o <= '0;
            rr_ptr  <= '0;
        end else if (any_grant) begin
            valid_o <= 1'b1;
            fdata_o <= sel_flit;
            vc_id_o <= arb_idx;
            rr_ptr  <= IW'((int'(arb_idx) + 1) % int'(NUM_VC));
        end else if (slot_free) begin
            valid_o <= 1'b0;
        end
    end

`ifdef VC_LINK_TX_FRAME_CHECK_EN
    frame_state_t      fs_q [NUM_VC];
    frame_state_t      fs_d [NUM_VC];
    logic [NUM_VC-1:0] viol_c;
    flit_type_t        gtype;
    logic              err_q;

    assign gtype = flit_type_t'(sel_flit[FLIT_W-1:FLIT_W-2]);

    always_ff @(posedge clk) begin
        for (int v = 0; v < int'(NUM_VC); v++) begin
            if (!arst) begin
                fs_q[v] <= FS_IDLE;
            end else begin
                fs_q[v] <= fs_d[v];
            end
        end
    end

    // Illegal types leave the state unchanged; only the error flag reacts.
    always_comb begin
        fs_d = fs_q;
        for (int v = 0; v < int'(NUM_VC); v++) begin
            if (grant[v]) begin
                case (fs_q[v])
                    FS_IDLE: if (gtype == FT_HEAD) fs_d[v] = FS_PKT;
                    FS_PKT:  if (gtype == FT_TAIL) fs_d[v] = FS_IDLE;
                    default: fs_d[v] = FS_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        viol_c = '0;
        for (int v = 0; v < int'(NUM_VC); v++) begin
            viol_c[v] = grant[v] && frame_violation(fs_q[v], gtype);
        end
    end

    always_ff @(posedge clk) begin
        if (!arst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | (|viol_c);
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_vc_link_tx.sv
// Self-checking bench for vc_link_tx: directed scenarios plus randomized traffic against a queue-free slot model.
module tb_vc_link_tx;

    localparam int N  = 3;
    localparam int FW = 34;

    logic              clk = 1'b0;
    logic              arst;
    logic [N*FW-1:0]   fdata_i;
    logic [N-1:0]      valid_i;
    logic [N-1:0]      ready_o;
    logic [FW-1:0]     fdata_o;
    logic [1:0]        vc_id_o;
    logic              valid_o;
    logic [N-1:0]      ready_i;
    logic              err_o;

    always #5 clk = ~clk;

    vc_link_tx #(.NUM_VC(N), .FLIT_W(FW)) dut (
        .clk     (clk),
        .arst    (arst),
        .fdata_i (fdata_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .fdata_o (fdata_o),
        .vc_id_o (vc_id_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .err_o   (err_o)
    );

    // Behavioural model of the link slot.
    logic          m_valid;
    logic [FW-1:0] m_data;
    int            m_vc;
    int            m_ptr;
    logic          m_err;
    logic          m_inpkt [N];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (!arst) return -1;
        if (m_valid && !ready_i[m_vc]) return -1;
        for (int k = 0; k < N; k++) begin
            int v;
            v = (m_ptr + k) % N;
            if (valid_i[v] && ready_i[v]) return v;
        end
        return -1;
    endfunction

    function automatic logic [N*FW-1:0] put(input logic [N*FW-1:0] b, input int vc, input logic [FW-1:0] f);
        b[vc*FW +: FW] = f;
        return b;
    endfunction

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] p);
        return {t, p};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_vc    = 0;
        m_ptr   = 0;
        m_err   = 1'b0;
        for (int v = 0; v < N; v++) m_inpkt[v] = 1'b0;
    endtask

    // One clock cycle: drive inputs after the falling edge, check ready_o, advance the model, check outputs.
    task automatic step(input logic rst_n, input logic [N-1:0] v, input logic [N-1:0] r,
                        input logic [N*FW-1:0] d);
        int            g;
        logic          free;
        logic [FW-1:0] f;
        logic [1:0]    t;
        arst    = rst_n;
        valid_i = v;
        ready_i = r;
        fdata_i = d;
        #1;
        g    = model_grant();
        free = !m_valid || ready_i[m_vc];
        check("ready_o", 64'(ready_o), (g >= 0) ? (64'd1 << g) : 64'd0);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (g >= 0) begin
            f       = d[g*FW +: FW];
            m_valid = 1'b1;
            m_data  = f;
            m_vc    = g;
            m_ptr   = (g + 1) % N;
`ifdef VC_LINK_TX_FRAME_CHECK_EN
            t = f[FW-1:FW-2];
            if (!m_inpkt[g]) begin
                if (t == 2'b01 || t == 2'b11) m_err = 1'b1;
                else if (t == 2'b00)          m_inpkt[g] = 1'b1;
            end else begin
                if (t == 2'b00 || t == 2'b10) m_err = 1'b1;
                else if (t == 2'b11)          m_inpkt[g] = 1'b0;
            end
`else
            t = 2'b00;
`endif
        end else if (free) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check("valid_o", 64'(valid_o), 64'(m_valid));
        check("vc_id_o", 64'(vc_id_o), 64'(m_vc));
        check("fdata_o", 64'(fdata_o), 64'(m_data));
        check("err_o",   64'(err_o),   64'(m_err));
    endtask

    function automatic logic [N*FW-1:0] rnd_data();
        logic [N*FW-1:0] b;
        logic [63:0]     x;
        b = '0;
        for (int v = 0; v < N; v++) begin
            x = {$urandom, $urandom};
            b[v*FW +: FW] = x[FW-1:0];
        end
        return b;
    endfunction

    logic [N*FW-1:0] d;

    initial begin
        model_reset();
        arst    = 1'b0;
        valid_i = '0;
        ready_i = '0;
        fdata_i = '0;
        @(negedge clk);

        // Reset held with all VCs valid.
        for (int i = 0; i < 3; i++) step(1'b0, 3'b111, 3'b111, rnd_data());
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_err",   64'(err_o),   64'd0);

        // Round-robin with everything eligible: 0,1,2,0,1,2.
        for (int i = 0; i < 6; i++) begin
            d = put('0, 0, mk(2'b10, 32'h100 + 32'(i)));
            d = put(d, 1, mk(2'b10, 32'h200 + 32'(i)));
            d = put(d, 2, mk(2'b10, 32'h300 + 32'(i)));
            step(1'b1, 3'b111, 3'b111, d);
            check("rr_seq", 64'(vc_id_o), 64'(i % 3));
            check("rr_valid", 64'(valid_o), 64'd1);
        end

        // Stall on VC1 while its downstream buffer is full.
        step(1'b1, 3'b010, 3'b111, put('0, 1, 34'h0_0000_0ABC));
        check("stall_vc", 64'(vc_id_o), 64'd1);
        check("stall_data", 64'(fdata_o), 64'h0ABC);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'b111, 3'b101, put(put(put('0, 0, mk(2'b10, 32'h1)), 1, mk(2'b10, 32'h2)), 2, mk(2'b10, 32'h3)));
            check("stall_hold", 64'(fdata_o), 64'h0ABC);
            check("stall_ready", 64'(ready_o), 64'd0);
        end
        step(1'b1, 3'b111, 3'b111, put(put(put('0, 0, mk(2'b10, 32'h11)), 1, mk(2'b10, 32'h12)), 2, mk(2'b10, 32'h13)));
        check("stall_resume_vc", 64'(vc_id_o), 64'd2);
        check("stall_resume_data", 64'(fdata_o), 64'h2_0000_0013);

        // Eligibility: VC1 blocked downstream.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'b111, 3'b101, rnd_data());
            check("elig_seq", 64'(vc_id_o), (i % 2 == 0) ? 64'd0 : 64'd2);
        end

        // Reset while a flit is stalled.
        step(1'b1, 3'b010, 3'b111, rnd_data());
        step(1'b1, 3'b111, 3'b101, rnd_data());
        check("mid_stall_valid", 64'(valid_o), 64'd1);
        step(1'b0, 3'b111, 3'b111, rnd_data());
        check("mid_rst_valid", 64'(valid_o), 64'd0);
        step(1'b1, 3'b111, 3'b111, rnd_data());
        check("mid_rst_first", 64'(vc_id_o), 64'd0);

        // Framing: legal packet sequence on VC0, then a stray BODY on VC2.
        step(1'b0, 3'b000, 3'b111, '0);
        step(1'b1, 3'b001, 3'b111, put('0, 0, mk(2'b00, 32'hA0)));
        step(1'b1, 3'b001, 3'b111, put('0, 0, mk(2'b01, 32'hA1)));
        step(1'b1, 3'b001, 3'b111, put('0, 0, mk(2'b11, 32'hA2)));
        step(1'b1, 3'b001, 3'b111, put('0, 0, mk(2'b10, 32'hA3)));
        check("frame_legal", 64'(err_o), 64'd0);
        step(1'b1, 3'b100, 3'b111, put('0, 2, mk(2'b01, 32'hB0)));
        check("frame_fwd", 64'(fdata_o), 64'h1_0000_00B0);
`ifdef VC_LINK_TX_FRAME_CHECK_EN
        check("frame_err", 64'(err_o), 64'd1);
`else
        check("frame_err", 64'(err_o), 64'd0);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(39, 0) != 0), 3'($urandom), 3'($urandom | $urandom), rnd_data());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
